muldiv_sequencer: RTL

Multi-cycle sequencer for the MUL and DIV instructions of the RV32 core. It sits beside the ULA in the execute path. When the control unit emits ULAControl 0110 (MUL) or 1000 (DIV), it captures the operands and runs an iterative shift-add multiply or restoring divide. It holds `stall` high until the result is ready, then presents the result for one cycle for writeback.

---
 rtl/muldiv_sequencer_if.sv | 22 ++
 rtl/muldiv_sequencer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer_if.sv
// Execute-stage handshake between the control path and the MUL/DIV sequencer.
interface muldiv_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             valid;
   logic [3:0]       ULAControl;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             stall;
   logic             done;
   logic [WIDTH-1:0] result;

   modport master (
      output valid, ULAControl, a, b,
      input  stall, done, result
   );

   modport slave (
      input  valid, ULAControl, a, b,
      output stall, done, result
   );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative shift-add MUL / restoring signed DIV; WIDTH+1 stall cycles (1 for div-by-zero/overflow).
// Stall is combinational while accepting and iterating; done pulses one cycle with result.
module muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic              clk,
   input  logic              reset,
   muldiv_sequencer_if.slave bus
);
   localparam int               CW      = $clog2(WIDTH);
   localparam logic [3:0]       OP_MUL  = 4'b0110;
   localparam logic [3:0]       OP_DIV  = 4'b1000;
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t           r_state, w_next;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_mcand, r_mplier, r_acc;
   logic [WIDTH-1:0] r_dvd, r_dvs, r_rem;
   logic             r_neg;
   logic [WIDTH-1:0] r_result;

   logic             w_is_mul, w_is_div, w_accept, w_div_zero, w_div_ovf, w_special;
   logic             w_stall, w_done, w_last, w_q_bit;
   logic [WIDTH-1:0] w_abs_a, w_abs_b, w_mul_sum, w_rem_next, w_quo_next;
   logic [WIDTH:0]   w_rem_shift, w_rem_diff;

   // Reset also masks acceptance so stall drops the moment reset is asserted.
   assign w_is_mul   = (bus.ULAControl == OP_MUL);
   assign w_is_div   = (bus.ULAControl == OP_DIV);
   assign w_accept   = !reset && (r_state == S_IDLE) && bus.valid && (w_is_mul || w_is_div);
   assign w_div_zero = (bus.b == '0);
   assign w_div_ovf  = (bus.a == MIN_NEG) && (bus.b == '1);
   assign w_special  = w_is_div && (w_div_zero || w_div_ovf);
   assign w_abs_a    = bus.a[WIDTH-1] ? -bus.a : bus.a;
   assign w_abs_b    = bus.b[WIDTH-1] ? -bus.b : bus.b;
   assign w_last     = (r_count == LAST);

   assign w_mul_sum  = r_acc + (r_mplier[0] ? r_mcand : '0);

   // The kept remainder is always below |b|, so WIDTH bits suffice between steps.
   assign w_rem_shift = {r_rem, r_dvd[WIDTH-1]};
   assign w_rem_diff  = w_rem_shift - {1'b0, r_dvs};
   assign w_q_bit     = ~w_rem_diff[WIDTH];
   assign w_rem_next  = w_q_bit ? w_rem_diff[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
   assign w_quo_next  = {r_acc[WIDTH-2:0], w_q_bit};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_stall = 1'b0;
      w_done  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_stall = 1'b1;
               if (w_special)     w_next = S_DONE;
               else if (w_is_div) w_next = S_DIV;
               else               w_next = S_MUL;
            end
         end
         S_MUL, S_DIV: begin
            w_stall = 1'b1;
            if (w_last) w_next = S_DONE;
         end
         S_DONE: begin
            w_done = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count  <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_dvd    <= '0;
         r_dvs    <= '0;
         r_rem    <= '0;
         r_neg    <= 1'b0;
         r_result <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_count  <= '0;
                  r_mcand  <= bus.a;
                  r_mplier <= bus.b;
                  r_acc    <= '0;
                  r_dvd    <= w_abs_a;
                  r_dvs    <= w_abs_b;
                  r_rem    <= '0;
                  r_neg    <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                  if (w_is_div && w_div_zero)     r_result <= '1;
                  else if (w_is_div && w_div_ovf) r_result <= MIN_NEG;
               end
            end
            S_MUL: begin
               r_acc    <= w_mul_sum;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_count  <= w_last ? '0 : r_count + CW'(1);
               if (w_last) r_result <= w_mul_sum;
            end
            S_DIV: begin
               r_rem   <= w_rem_next;
               r_dvd   <= r_dvd << 1;
               r_acc   <= w_quo_next;
               r_count <= w_last ? '0 : r_count + CW'(1);
               if (w_last) r_result <= r_neg ? -w_quo_next : w_quo_next;
            end
            default: ;
         endcase
      end
   end

   assign bus.stall  = w_stall;
   assign bus.done   = w_done;
   assign bus.result = r_result;
endmodule
